// File: rtl/user_id_auth.sv
// Keypad user-ID assembler and authoriser: shifts in NUM_DIGITS digits, matches against USER_TABLE, holds a grant until logout.
// Optional lockout after MAX_FAIL consecutive rejects is built when USER_ID_LOCKOUT_EN is defined.
module user_id_auth #(
    parameter int DIGIT_W     = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_USERS   = 4,
    parameter logic [NUM_USERS*DIGIT_W*NUM_DIGITS-1:0] USER_TABLE = 64'h1234_5678_ABC1_9999,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    localparam int ID_W       = DIGIT_W * NUM_DIGITS,
    localparam int IDX_W      = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_input,
    input  logic [DIGIT_W-1:0] id_input,
    input  logic               logout,
    output logic [ID_W-1:0]    id_output,
    output logic               user_allow,
    output logic [IDX_W-1:0]   user_seg,
    output logic               id_fail,
    output logic               locked
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_GRANTED
`ifdef USER_ID_LOCKOUT_EN
        , ST_LOCKED
`endif
    } state_t;

    state_t             state_q, state_d;
    logic               load_q;
    logic               arm_q, arm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d, id_shift;
    logic               allow_q, allow_d;
    logic [IDX_W-1:0]   seg_q, seg_d;
    logic               fail_q, fail_d;
    logic [NUM_USERS-1:0] match;
    logic [IDX_W-1:0]   match_idx;
    logic               accept;

`ifdef USER_ID_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);
    logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_FAIL + LOCK_CYCLES) != 0;
`endif

    generate
        if (NUM_DIGITS > 1) begin : g_shift
            assign id_shift = {id_q[ID_W-DIGIT_W-1:0], id_input};
        end else begin : g_shift_single
            assign id_shift = id_input;
        end
        for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_match
            assign match[gi] = (id_q == USER_TABLE[gi*ID_W +: ID_W]);
        end
    endgenerate

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        match_idx = '0;
        for (int k = NUM_USERS - 1; k >= 0; k--) begin
            if (match[k]) match_idx = IDX_W'(k);
        end
    end

    // arm_q blocks a strobe that was already high when reset released.
    assign arm_d  = arm_q | ~load_input;
    assign accept = load_input & ~load_q & arm_q & (state_q == ST_ENTRY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        allow_d = allow_q;
        seg_d   = seg_q;
        fail_d  = 1'b0;
`ifdef USER_ID_LOCKOUT_EN
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
`endif
        case (state_q)
            ST_ENTRY: begin
                if (logout) begin
                    cnt_d = '0;
                    id_d  = '0;
                end else if (accept) begin
                    id_d = id_shift;
                    if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (|match) begin
                    state_d = ST_GRANTED;
                    allow_d = 1'b1;
                    seg_d   = match_idx;
`ifdef USER_ID_LOCKOUT_EN
                    fail_cnt_d = '0;
`endif
                end else begin
                    state_d = ST_ENTRY;
                    fail_d  = 1'b1;
                    id_d    = '0;
`ifdef USER_ID_LOCKOUT_EN
                    if (fail_cnt_q >= FAIL_W'(MAX_FAIL - 1)) begin
                        fail_cnt_d = FAIL_W'(MAX_FAIL);
                        timer_d    = TMR_W'(LOCK_CYCLES - 1);
                        state_d    = ST_LOCKED;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                    end
`endif
                end
            end
            ST_GRANTED: begin
                if (logout) begin
                    state_d = ST_ENTRY;
                    id_d    = '0;
                    allow_d = 1'b0;
                    seg_d   = '0;
                end
            end
`ifdef USER_ID_LOCKOUT_EN
            ST_LOCKED: begin
                if (timer_q == '0) begin
                    state_d    = ST_ENTRY;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
`endif
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ENTRY;
            load_q  <= 1'b0;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
            id_q    <= '0;
            allow_q <= 1'b0;
            seg_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_input;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            allow_q <= allow_d;
            seg_q   <= seg_d;
            fail_q  <= fail_d;
        end
    end

`ifdef USER_ID_LOCKOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
        end
    end
    assign locked = (state_q == ST_LOCKED);
`else
    assign locked = 1'b0;
`endif

    assign id_output  = id_q;
    assign user_allow = allow_q;
    assign user_seg   = seg_q;
    assign id_fail    = fail_q;

endmodule
